// File: rtl/dump_ctrl_pkg.sv
// Shared definitions for the end-of-run memory dump controller.
// Holds the data-path width, the default finish address and dump window
// constants, and the controller state encoding.
package dump_ctrl_pkg;

  // Width of the CPU data path: address, store data and memory read data.
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] FINISH_ADDR_DEF = 32'h0000_7fff;
  localparam logic [15:0]       DUMP_BASE_DEF   = 16'd256;
  localparam logic [15:0]       DUMP_END_DEF    = 16'd1023;

  // IDLE: CPU running; DUMP: streaming dmem words; CNT: streaming the cycle
  // count (only reachable with DUMP_CYCLE_COUNT_EN); DONE: parked until reset.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    CNT  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/dump_ctrl.sv
// Purpose: watches CPU stores for the finish write, then halts the CPU and
//          streams dmem[DUMP_BASE..DUMP_END] out over a valid/ready port.
// Latency: halt and the first beat appear the cycle after the finish write;
//          one beat per cycle while out_ready is high.
// Backpressure: out_ready low holds out_data/mem_a/out_last stable; no beats
//          are dropped or duplicated.
//
// Ports:
//   clk, rst_n          single clock, synchronous active-low reset
//   daddr, dwdata, we   CPU store bus snooped for the finish write
//   halt                freezes the CPU from the cycle after the finish write
//   mem_a, mem_rd       dmem second read port (asynchronous read)
//   out_valid, out_ready, out_data, out_last   dump stream
//   done, status        dump finished; store data of the finish write
//
// Optional feature: define DUMP_CYCLE_COUNT_EN to count IDLE cycles from
// reset to the finish write and append that count as one extra final beat.
module dump_ctrl
  import dump_ctrl_pkg::*;
#(
  parameter logic [DATA_W-1:0] FINISH_ADDR = FINISH_ADDR_DEF,
  parameter logic [15:0]       DUMP_BASE   = DUMP_BASE_DEF,
  parameter logic [15:0]       DUMP_END    = DUMP_END_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] daddr,
  input  logic [DATA_W-1:0] dwdata,
  input  logic              we,
  output logic              halt,
  output logic [15:0]       mem_a,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done,
  output logic [DATA_W-1:0] status
);

  state_e            state_q, state_d;
  logic [15:0]       idx_q, idx_d;
  logic [DATA_W-1:0] status_q, status_d;
  logic              halt_q, halt_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;

  logic finish_hit;
  logic fire;

  // Full-width compare: aliases of FINISH_ADDR in upper bits must not match.
  assign finish_hit = we && (daddr == FINISH_ADDR);
  assign fire       = out_valid_q && out_ready;

`ifdef DUMP_CYCLE_COUNT_EN
  logic [DATA_W-1:0] cyc_cnt_q, cyc_cnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    status_d = status_q;
`ifdef DUMP_CYCLE_COUNT_EN
    cyc_cnt_d = cyc_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (finish_hit) begin
          state_d  = DUMP;
          idx_d    = DUMP_BASE;
          status_d = dwdata;
        end
`ifdef DUMP_CYCLE_COUNT_EN
        // Counter freezes on the finish cycle itself and saturates at all-ones.
        else if (cyc_cnt_q != {DATA_W{1'b1}}) begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
`endif
      end
      DUMP: begin
        if (fire) begin
          if (idx_q == DUMP_END) begin
`ifdef DUMP_CYCLE_COUNT_EN
            state_d = CNT;
`else
            state_d = DONE;
`endif
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end
      end
      CNT: begin
        if (fire) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = DONE;
      end
    endcase

    // Outputs are registered from the next-state view so they line up with
    // state_q on the following cycle.
    halt_d      = (state_d != IDLE);
    out_valid_d = (state_d == DUMP) || (state_d == CNT);
    done_d      = (state_d == DONE);
`ifdef DUMP_CYCLE_COUNT_EN
    out_last_d  = (state_d == CNT);
`else
    out_last_d  = (state_d == DUMP) && (idx_d == DUMP_END);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= DUMP_BASE;
      status_q    <= '0;
      halt_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef DUMP_CYCLE_COUNT_EN
      cyc_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      status_q    <= status_d;
      halt_q      <= halt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
`ifdef DUMP_CYCLE_COUNT_EN
      cyc_cnt_q   <= cyc_cnt_d;
`endif
    end
  end

  assign halt      = halt_q;
  assign mem_a     = idx_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign status    = status_q;

  // mem_rd follows mem_a combinationally, and idx_q only moves on a
  // handshake, so out_data is stable across stalls.
  always_comb begin
    out_data = '0;
    if (state_q == DUMP) begin
      out_data = mem_rd;
    end
`ifdef DUMP_CYCLE_COUNT_EN
    else if (state_q == CNT) begin
      out_data = cyc_cnt_q;
    end
`endif
  end

endmodule

// File: tb/tb_dump_ctrl.sv
module tb_dump_ctrl;
  import dump_ctrl_pkg::*;

  localparam int          BASE = 256;
  localparam int          LAST = 1023;
  localparam logic [31:0] FIN  = 32'h0000_7fff;
`ifdef DUMP_CYCLE_COUNT_EN
  localparam int NBEATS = LAST - BASE + 2;
`else
  localparam int NBEATS = LAST - BASE + 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dwdata = '0;
  logic        we = 1'b0;
  logic        halt;
  logic [15:0] mem_a;
  logic [31:0] mem_rd;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        done;
  logic [31:0] status;

  logic [31:0] dmem [0:1023];
  assign mem_rd = dmem[mem_a[9:0]];

  dump_ctrl dut (
    .clk(clk), .rst_n(rst_n), .daddr(daddr), .dwdata(dwdata), .we(we),
    .halt(halt), .mem_a(mem_a), .mem_rd(mem_rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done), .status(status)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_rst = 0;
  int    beats = 0;
  int    ready_mode = 0;
  bit    model_idle = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Edge counter and record of the most recent edge that saw reset asserted.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) last_rst = cyc;
  end

  // out_ready pattern generator.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 3 == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on every handshake, checks stall stability.
  initial begin
    bit          prev_stall;
    logic [31:0] prev_data;
    logic [15:0] prev_a;
    logic        prev_last;
    beat_t       e;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (prev_stall) begin
          chk("stall_data", out_data, prev_data);
          chk("stall_mem_a", {16'd0, mem_a}, {16'd0, prev_a});
          chk("stall_last", {31'd0, out_last}, {31'd0, prev_last});
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=%h required=none", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", out_data, e.d);
            chk("beat_last", {31'd0, out_last}, {31'd0, e.l});
          end
          beats++;
        end
        prev_stall = !out_ready;
        prev_data  = out_data;
        prev_a     = mem_a;
        prev_last  = out_last;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    model_idle = 1'b1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) dmem[i] = $urandom;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; daddr = a; dwdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
    // Reference: a finish store while idle and out of reset starts a dump of
    // the whole window; the optional final beat is the count of idle edges
    // between the reset edge and the finish edge.
    if (a == FIN && rst_n && model_idle) begin
      model_idle = 1'b0;
      for (int i = BASE; i <= LAST; i++) begin
`ifdef DUMP_CYCLE_COUNT_EN
        exp_q.push_back('{d: dmem[i], l: 1'b0});
`else
        exp_q.push_back('{d: dmem[i], l: (i == LAST)});
`endif
      end
`ifdef DUMP_CYCLE_COUNT_EN
      exp_q.push_back('{d: 32'(cyc - last_rst - 1), l: 1'b1});
`endif
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 20000 && !done; k++) begin
      @(posedge clk);
      #1;
    end
    chk("done_reached", {31'd0, done}, 32'd1);
    chk("done_halt", {31'd0, halt}, 32'd1);
    chk("done_valid", {31'd0, out_valid}, 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("beat_count", 32'(beats), 32'(NBEATS));
  endtask

  initial begin
    logic [31:0] d;

    // Reset state.
    fill_mem();
    do_reset(3);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mem_a", {16'd0, mem_a}, 32'(BASE));
    chk("rst_data", out_data, 32'd0);
    chk("rst_status", status, 32'd0);

    // Near-miss stores are ignored.
    store(32'h0000_7ffe, 32'haaaa);
    chk("miss1_halt", {31'd0, halt}, 32'd0);
    chk("miss1_valid", {31'd0, out_valid}, 32'd0);
    store(32'h0001_7fff, 32'hbbbb);
    chk("miss2_halt", {31'd0, halt}, 32'd0);
    chk("miss2_status", status, 32'd0);

    // Run 1: always ready.
    ready_mode = 0;
    beats = 0;
    store(FIN, 32'h1234);
    chk("fin_halt", {31'd0, halt}, 32'd1);
    chk("fin_status", status, 32'h1234);
    chk("fin_valid", {31'd0, out_valid}, 32'd1);
    chk("fin_mem_a", {16'd0, mem_a}, 32'(BASE));
    repeat (5) @(posedge clk);
    #1;
    store(FIN, 32'h5555);
    chk("refinish_status", status, 32'h1234);
    wait_done();
    store(FIN, 32'h6666);
    chk("done_refinish_status", status, 32'h1234);
    chk("done_hold", {31'd0, done}, 32'd1);

    // Run 2: ready one cycle in three.
    ready_mode = 1;
    fill_mem();
    do_reset(2);
    beats = 0;
    repeat (7) @(posedge clk);
    #1;
    d = $urandom;
    store(FIN, d);
    chk("run2_status", status, d);
    wait_done();

    // Run 3: random ready, reset at beat 100, then a fresh dump.
    ready_mode = 2;
    fill_mem();
    do_reset(2);
    beats = 0;
    store(FIN, 32'hcafe);
    for (int k = 0; k < 5000 && beats < 100; k++) begin
      @(posedge clk);
      #1;
    end
    chk("reached_beat100", {31'd0, beats >= 100}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_halt", {31'd0, halt}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_mem_a", {16'd0, mem_a}, 32'(BASE));
    chk("abort_status", status, 32'd0);
    rst_n = 1'b1;
    exp_q.delete();
    model_idle = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_stays_idle", {31'd0, out_valid | halt}, 32'd0);
    beats = 0;
    store(FIN, 32'hbeef);
    chk("restart_mem_a", {16'd0, mem_a}, 32'(BASE));
    wait_done();

    // Reset and finish write in the same cycle: reset wins.
    rst_n = 1'b0;
    store(FIN, 32'h0099);
    rst_n = 1'b1;
    model_idle = 1'b1;
    chk("rstwin_halt", {31'd0, halt}, 32'd0);
    chk("rstwin_status", status, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rstwin_valid", {31'd0, out_valid}, 32'd0);
    chk("rstwin_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
